// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter with a ready/valid style byte input and a
// line-idle indicator that asserts after IDLE_BITS quiet bit-times.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned IDLE_BITS    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_req,
    output logic       tx_cts,
    output logic       tx_idle,
    output logic       ser_tx
);

    localparam int unsigned CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDLE_MAX = IDLE_BITS * CLKS_PER_BIT;
    localparam int unsigned IDLE_W   = $clog2(IDLE_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDLE_W-1:0] IDLE_SAT  = IDLE_W'(IDLE_MAX);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_bit_idx;
    logic                r_stop_idx;
    logic [7:0]          r_shift;
    logic                r_ser;
    logic                r_busy;
    logic [IDLE_W-1:0]   r_idle_cnt;

    logic                w_accept;
    logic                w_bit_end;

    assign w_accept  = tx_req & ~r_busy;
    assign w_bit_end = (r_cnt == CNT_LAST);

    assign tx_cts  = ~r_busy;
    assign tx_idle = (r_idle_cnt == IDLE_SAT);
    assign ser_tx  = r_ser;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_ser      <= 1'b1;
            r_busy     <= 1'b0;
            r_idle_cnt <= '0;
        end else begin
            // Idle time is counted only while the transmitter is free and not taking a byte.
            if (w_accept) begin
                r_idle_cnt <= '0;
            end else if (!r_busy && r_idle_cnt != IDLE_SAT) begin
                r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end

            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_state <= StStart;
                        r_busy  <= 1'b1;
                        r_ser   <= 1'b0;
                        r_cnt   <= '0;
                        r_shift <= tx_data;
                    end
                end
                StStart: begin
                    if (w_bit_end) begin
                        r_state   <= StData;
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_ser     <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StData: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state    <= StStop;
                            r_stop_idx <= 1'b0;
                            r_ser      <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_ser     <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StStop: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_stop_idx == STOP_LAST) begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_ser   <= 1'b1;
                end
            endcase
        end
    end

endmodule
